alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit nibbles; the legal range is 1..8.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port start, input, 1 bit: requests an operation.
REQ-005 Port op, input, 3 bits: ALU operation, passed through to the ALU.
REQ-006 Port bank, input, 1 bit: ALU operation bank, passed through to the ALU.
REQ-007 Port cin, input, 1 bit: carry into the least-significant nibble.
REQ-008 Ports a_in and b_in, input, 4*NIBBLES bits each: the wide operands.
REQ-009 Port busy, output, 1 bit: an operation is being sequenced.
REQ-010 Port done, output, 1 bit: one-cycle completion pulse.
REQ-011 Port result, output, 4*NIBBLES bits: the wide result.
REQ-012 Port flags, output, 4 bits: combined flags, bit order [3]=N, [2]=Z, [1]=V, [0]=C.
REQ-013 Ports alu_a and alu_b, output, 4 bits each: nibble operands to the external combinational 4-bit ALU.
REQ-014 Ports alu_op (output, 3 bits), alu_bank (output, 1 bit) and alu_cin (output, 1 bit): drive the external ALU.
REQ-015 Ports alu_result and alu_flags, input, 4 bits each: the ALU's same-cycle answer, with alu_flags in NZVC order.

Function
REQ-016 The block SHALL have states IDLE, RUN and DONE.
REQ-017 In IDLE or DONE, start=1 SHALL latch a_in, b_in, op, bank and cin, clear the nibble index to 0, and enter RUN on the next cycle.
REQ-018 In RUN, the block SHALL drive alu_a and alu_b with nibble[idx] of the latched operands, alu_op and alu_bank with the latched values, and alu_cin with the carry register.
REQ-019 In RUN, each cycle SHALL write alu_result into nibble[idx] of the working register, load the carry register from alu_flags[0], AND alu_flags[2] into the Z accumulator, and increment idx.
REQ-020 In RUN with idx==NIBBLES-1, the block SHALL capture N, V and C of that nibble, enter DONE, and copy the working register to result.
REQ-021 The carry register SHALL be loaded with cin on start; the Z accumulator SHALL be set to 1 on start.
REQ-022 Combined flags SHALL be N, V and C of the top nibble and Z equal to the AND of the Z flags of all nibbles.
REQ-023 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-024 DONE SHALL last one cycle and then return to IDLE unless start is accepted in that cycle.
REQ-025 Latency: a start accepted in cycle 0 SHALL give done=1 in cycle NIBBLES+1; NIBBLES=1 gives cycle 2.
REQ-026 start while busy SHALL be ignored, with no effect on the operation in flight.
REQ-027 result and flags SHALL hold their values from the DONE cycle until the next DONE; they SHALL NOT change during RUN.
REQ-028 Outside RUN, alu_a, alu_b, alu_op, alu_bank and alu_cin SHALL be 0.

Reset
REQ-029 With reset=1 at a clock edge, the block SHALL enter IDLE and clear busy, done, result, flags, idx, the carry register and the working register to 0.
REQ-030 Reset SHALL take priority over start; reset during RUN SHALL abandon the operation with no done pulse.

Configuration
REQ-031 Macro ALU_SEQ_FLAGS_EN: when defined, flags SHALL behave per REQ-022 and REQ-027.
REQ-032 When ALU_SEQ_FLAGS_EN is undefined, flags SHALL be constant 0, and the Z accumulator and N/V/C capture logic SHALL be absent; the carry chain SHALL still operate.

Structure
REQ-033 Shared package alu_seq_pkg SHALL hold the state type (IDLE, RUN, DONE) and the flag bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0.
REQ-034 The block SHALL have no sub-module; the 4-bit ALU SHALL be instantiated by the parent and connected through the alu_* ports.

Verification (bench ALU model: op=0, bank=0 computes A+B+Cin with NZVC; NIBBLES=4; macro defined unless stated)
REQ-035 The bench SHALL cover: a_in=0x00FF, b_in=0x0001, cin=0 -> result=0x0100, flags=4'b0000, done in cycle 5.
REQ-036 The bench SHALL cover: a_in=0xFFFF, b_in=0x0001, cin=0 -> result=0x0000, flags=4'b0101 (Z=1, C=1); a_in=0x7FFF, b_in=0x0000, cin=1 -> result=0x8000, flags=4'b1010.
REQ-037 The bench SHALL cover: start pulsed in cycles 0 and 2 -> one operation only, with the second start ignored; start asserted in the DONE cycle -> the second operation is accepted and busy is set the next cycle.
REQ-038 The bench SHALL cover: reset asserted in cycle 2 of an operation -> next cycle all outputs 0, state IDLE, no done pulse; a following 0x1234+0x1111 -> result 0x2345.
REQ-039 The bench SHALL cover: with the macro undefined, 0xFFFF+0x0001 -> result 0x0000, flags=4'b0000.
REQ-040 The bench SHALL cover: NIBBLES=1, a_in=0xF, b_in=0x1 -> result 0x0, done in cycle 2, flags C=1 and Z=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/alu_seq.sv
// Sequences a wide operation through an external 4-bit ALU, one nibble per cycle.
// Optional feature: define ALU_SEQ_FLAGS_EN to produce combined NZVC flags.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic                 bank,
  input  logic                 cin,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic [3:0]           flags,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [2:0]           alu_op,
  output logic                 alu_bank,
  output logic                 alu_cin,
  input  logic [3:0]           alu_result,
  input  logic [3:0]           alu_flags
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   work_q, work_d, result_q, result_d;
  logic [2:0]     op_q, op_d;
  logic           bank_q, bank_d, carry_q, carry_d;
  logic [IW-1:0]  idx_q, idx_d;
`ifdef ALU_SEQ_FLAGS_EN
  logic           zacc_q, zacc_d;
  logic [3:0]     flags_q, flags_d;
`endif

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    bank_d   = bank_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    work_d   = work_q;
    result_d = result_q;
`ifdef ALU_SEQ_FLAGS_EN
    zacc_d   = zacc_q;
    flags_d  = flags_q;
`endif
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = '0;
    alu_bank = 1'b0;
    alu_cin  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          a_d     = a_in;
          b_d     = b_in;
          op_d    = op;
          bank_d  = bank;
          carry_d = cin;
          idx_d   = '0;
`ifdef ALU_SEQ_FLAGS_EN
          zacc_d  = 1'b1;
`endif
        end
      end
      RUN: begin
        alu_a    = a_q[4*int'(idx_q) +: 4];
        alu_b    = b_q[4*int'(idx_q) +: 4];
        alu_op   = op_q;
        alu_bank = bank_q;
        alu_cin  = carry_q;
        work_d[4*int'(idx_q) +: 4] = alu_result;
        carry_d  = alu_flags[FLAG_C];
        idx_d    = IW'(idx_q + 1'b1);
`ifdef ALU_SEQ_FLAGS_EN
        zacc_d   = zacc_q & alu_flags[FLAG_Z];
`endif
        // The last nibble's answer is folded in here so result is complete on entry to DONE.
        if (idx_q == LAST_IDX) begin
          state_d  = DONE;
          result_d = work_d;
`ifdef ALU_SEQ_FLAGS_EN
          flags_d[FLAG_N] = alu_flags[FLAG_N];
          flags_d[FLAG_Z] = zacc_q & alu_flags[FLAG_Z];
          flags_d[FLAG_V] = alu_flags[FLAG_V];
          flags_d[FLAG_C] = alu_flags[FLAG_C];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      bank_q   <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      zacc_q   <= 1'b0;
      flags_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      bank_q   <= bank_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      work_q   <= work_d;
      result_q <= result_d;
`ifdef ALU_SEQ_FLAGS_EN
      zacc_q   <= zacc_d;
      flags_q  <= flags_d;
`endif
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign flags  = flags_q;
`else
  assign flags  = '0;
`endif

endmodule
